// File: rtl/gb80_pkg.sv
// Shared register/pair encodings for the 8-bit CPU register file.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package gb80_pkg;

   localparam int NUM_REGS = 8;

   // Default writable bits of F: only the four flag bits Z N H C exist.
   localparam logic [7:0] FLAG_MASK_DEFAULT = 8'hF0;

   typedef enum logic [2:0] {
      REG_B = 3'd0,
      REG_C = 3'd1,
      REG_D = 3'd2,
      REG_E = 3'd3,
      REG_H = 3'd4,
      REG_L = 3'd5,
      REG_F = 3'd6,
      REG_A = 3'd7
   } byte_code_e;

   typedef enum logic [1:0] {
      PAIR_BC = 2'd0,
      PAIR_DE = 2'd1,
      PAIR_HL = 2'd2,
      PAIR_AF = 2'd3
   } pair_code_e;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_RSVD = 2'b11
   } pair_op_e;

   // High byte of a pair (first letter of its name).
   function automatic byte_code_e pair_hi_code(input logic [1:0] sel);
      case (pair_code_e'(sel))
         PAIR_BC: return REG_B;
         PAIR_DE: return REG_D;
         PAIR_HL: return REG_H;
         default: return REG_A;
      endcase
   endfunction

   // Low byte of a pair (second letter of its name).
   function automatic byte_code_e pair_lo_code(input logic [1:0] sel);
      case (pair_code_e'(sel))
         PAIR_BC: return REG_C;
         PAIR_DE: return REG_E;
         PAIR_HL: return REG_L;
         default: return REG_F;
      endcase
   endfunction

endpackage

// File: rtl/pair_incdec.sv
// Wrapping increment/decrement of a register-pair value.
// Latency: combinational, zero cycles.
// Backpressure: none; result is valid whenever the inputs are.
module pair_incdec
   import gb80_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic [1:0]       i_op,
   output logic [WIDTH-1:0] o_value,
   output logic             o_active
);

   // Add or subtract one; natural WIDTH-bit overflow gives the wrap.
   always_comb begin
      o_value  = i_value;
      o_active = 1'b0;
      case (pair_op_e'(i_op))
         OP_INC: begin
            o_value  = i_value + WIDTH'(1);
            o_active = 1'b1;
         end
         OP_DEC: begin
            o_value  = i_value - WIDTH'(1);
            o_active = 1'b1;
         end
         default: begin
            o_value  = i_value;
            o_active = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pair_register_file.sv
// Eight byte registers (B C D E H L F A) with byte and 16-bit pair access.
// Latency: writes land at the edge; reads are registered, 1 cycle, write-first.
// Backpressure: none; every request is accepted each cycle.
module pair_register_file
   import gb80_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    ADDRESS_WIDTH = 3,
   parameter logic [DATA_WIDTH-1:0] FLAG_MASK     = DATA_WIDTH'(FLAG_MASK_DEFAULT)
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_wr_en,
   input  logic [ADDRESS_WIDTH-1:0]  i_wr_addr,
   input  logic [DATA_WIDTH-1:0]     i_wr_data,
   input  logic                      i_rd_en_a,
   input  logic                      i_rd_en_b,
   input  logic [ADDRESS_WIDTH-1:0]  i_rd_addr_a,
   input  logic [ADDRESS_WIDTH-1:0]  i_rd_addr_b,
   output logic [DATA_WIDTH-1:0]     o_rd_data_a,
   output logic [DATA_WIDTH-1:0]     o_rd_data_b,
   input  logic [1:0]                i_pair_sel,
   input  logic                      i_pair_wr_en,
   input  logic [2*DATA_WIDTH-1:0]   i_pair_wr_data,
   input  logic [1:0]                i_pair_op,
   input  logic                      i_pair_rd_en,
   output logic [2*DATA_WIDTH-1:0]   o_pair_data
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   byte_code_e      hi_code;
   byte_code_e      lo_code;
   logic [PW-1:0]   pair_cur;
   logic [PW-1:0]   pair_step;
   logic            step_active;
   logic            op_en;

   logic [DATA_WIDTH-1:0] rd_a_next;
   logic [DATA_WIDTH-1:0] rd_b_next;
   logic [PW-1:0]         pair_rd_next;

   assign hi_code  = pair_hi_code(i_pair_sel);
   assign lo_code  = pair_lo_code(i_pair_sel);
   assign pair_cur = {regs_q[hi_code], regs_q[lo_code]};

   pair_incdec #(
      .WIDTH (PW)
   ) u_incdec (
      .i_value  (pair_cur),
      .i_op     (i_pair_op),
      .o_value  (pair_step),
      .o_active (step_active)
   );

   // AF is not a counter pair; inc/dec on it is dropped.
   assign op_en = step_active && (pair_code_e'(i_pair_sel) != PAIR_AF);

   // Next register state: later assignments win, so apply byte write,
   // then pair op, then pair write, and finally clamp F to its live bits.
   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_d[k] = regs_q[k];
         if (i_wr_en && (i_wr_addr == ADDRESS_WIDTH'(k))) begin
            regs_d[k] = i_wr_data;
         end
      end
      if (op_en) begin
         regs_d[hi_code] = pair_step[PW-1:DATA_WIDTH];
         regs_d[lo_code] = pair_step[DATA_WIDTH-1:0];
      end
      if (i_pair_wr_en) begin
         regs_d[hi_code] = i_pair_wr_data[PW-1:DATA_WIDTH];
         regs_d[lo_code] = i_pair_wr_data[DATA_WIDTH-1:0];
      end
      regs_d[REG_F] = regs_d[REG_F] & FLAG_MASK;
   end

   // Read muxes look at next state so same-cycle writes are visible.
   always_comb begin
      rd_a_next = '0;
      rd_b_next = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (i_rd_addr_a == ADDRESS_WIDTH'(k)) begin
            rd_a_next = regs_d[k];
         end
         if (i_rd_addr_b == ADDRESS_WIDTH'(k)) begin
            rd_b_next = regs_d[k];
         end
      end
      pair_rd_next = {regs_d[hi_code], regs_d[lo_code]};
   end

   // Register state and read outputs; reset clears everything and wins.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
         o_rd_data_a <= '0;
         o_rd_data_b <= '0;
         o_pair_data <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= regs_d[k];
         end
         if (i_rd_en_a) begin
            o_rd_data_a <= rd_a_next;
         end
         if (i_rd_en_b) begin
            o_rd_data_b <= rd_b_next;
         end
         if (i_pair_rd_en) begin
            o_pair_data <= pair_rd_next;
         end
      end
   end

endmodule

// File: tb/tb_pair_register_file.sv
// Directed self-checking bench for pair_register_file.
// Latency: inputs applied 1 time unit after an edge, outputs sampled likewise.
// Backpressure: n/a.
module tb_pair_register_file;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_wr_en;
   logic [2:0]  i_wr_addr;
   logic [7:0]  i_wr_data;
   logic        i_rd_en_a;
   logic        i_rd_en_b;
   logic [2:0]  i_rd_addr_a;
   logic [2:0]  i_rd_addr_b;
   logic [7:0]  o_rd_data_a;
   logic [7:0]  o_rd_data_b;
   logic [1:0]  i_pair_sel;
   logic        i_pair_wr_en;
   logic [15:0] i_pair_wr_data;
   logic [1:0]  i_pair_op;
   logic        i_pair_rd_en;
   logic [15:0] o_pair_data;

   int checks   = 0;
   int failures = 0;

   pair_register_file dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_wr_en        (i_wr_en),
      .i_wr_addr      (i_wr_addr),
      .i_wr_data      (i_wr_data),
      .i_rd_en_a      (i_rd_en_a),
      .i_rd_en_b      (i_rd_en_b),
      .i_rd_addr_a    (i_rd_addr_a),
      .i_rd_addr_b    (i_rd_addr_b),
      .o_rd_data_a    (o_rd_data_a),
      .o_rd_data_b    (o_rd_data_b),
      .i_pair_sel     (i_pair_sel),
      .i_pair_wr_en   (i_pair_wr_en),
      .i_pair_wr_data (i_pair_wr_data),
      .i_pair_op      (i_pair_op),
      .i_pair_rd_en   (i_pair_rd_en),
      .o_pair_data    (o_pair_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic clear_inputs();
      i_reset        = 1'b1;
      i_wr_en        = 1'b0;
      i_wr_addr      = 3'd0;
      i_wr_data      = 8'h00;
      i_rd_en_a      = 1'b0;
      i_rd_en_b      = 1'b0;
      i_rd_addr_a    = 3'd0;
      i_rd_addr_b    = 3'd0;
      i_pair_sel     = 2'd0;
      i_pair_wr_en   = 1'b0;
      i_pair_wr_data = 16'h0000;
      i_pair_op      = 2'b00;
      i_pair_rd_en   = 1'b0;
   endtask

   // One clock edge, then release all one-shot controls.
   task automatic tick();
      @(posedge i_clk);
      #1;
      clear_inputs();
   endtask

   task automatic wr_byte(input logic [2:0] addr, input logic [7:0] data);
      i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
      tick();
   endtask

   task automatic wr_pair(input logic [1:0] sel, input logic [15:0] data);
      i_pair_wr_en = 1'b1; i_pair_sel = sel; i_pair_wr_data = data;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      tick();
      checks++;
      if (o_rd_data_a !== 8'h00) begin
         failures++; $display("FAIL reset_rd_a got=%h exp=00", o_rd_data_a);
      end
      checks++;
      if (o_rd_data_b !== 8'h00) begin
         failures++; $display("FAIL reset_rd_b got=%h exp=00", o_rd_data_b);
      end
      checks++;
      if (o_pair_data !== 16'h0000) begin
         failures++; $display("FAIL reset_pair got=%h exp=0000", o_pair_data);
      end
   endtask

   task automatic test_pair_read();
      wr_byte(3'd0, 8'h12);
      wr_byte(3'd1, 8'h34);
      i_pair_rd_en = 1'b1; i_pair_sel = 2'd0;
      tick();
      checks++;
      if (o_pair_data !== 16'h1234) begin
         failures++; $display("FAIL pair_read_bc got=%h exp=1234", o_pair_data);
      end
      // Hold: an idle cycle must not disturb the registered output.
      tick();
      checks++;
      if (o_pair_data !== 16'h1234) begin
         failures++; $display("FAIL pair_read_hold got=%h exp=1234", o_pair_data);
      end
      // Write-first pair read of DE in the writing cycle.
      i_pair_wr_en = 1'b1; i_pair_sel = 2'd1; i_pair_wr_data = 16'hBEEF;
      i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'hBEEF) begin
         failures++; $display("FAIL pair_write_first_de got=%h exp=beef", o_pair_data);
      end
   endtask

   task automatic test_flag_mask();
      wr_byte(3'd6, 8'hFF);
      i_rd_en_a = 1'b1; i_rd_addr_a = 3'd6;
      tick();
      checks++;
      if (o_rd_data_a !== 8'hF0) begin
         failures++; $display("FAIL flag_mask_f got=%h exp=f0", o_rd_data_a);
      end
      wr_byte(3'd7, 8'h5A);
      i_rd_en_a = 1'b1; i_rd_addr_a = 3'd7;
      i_rd_en_b = 1'b1; i_rd_addr_b = 3'd7;
      tick();
      checks++;
      if (o_rd_data_a !== 8'h5A) begin
         failures++; $display("FAIL dual_read_a got=%h exp=5a", o_rd_data_a);
      end
      checks++;
      if (o_rd_data_b !== 8'h5A) begin
         failures++; $display("FAIL dual_read_b got=%h exp=5a", o_rd_data_b);
      end
      // Pair write to AF is masked on the F byte, seen write-first.
      i_pair_wr_en = 1'b1; i_pair_sel = 2'd3; i_pair_wr_data = 16'h1234;
      i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'h1230) begin
         failures++; $display("FAIL pair_write_af_mask got=%h exp=1230", o_pair_data);
      end
   endtask

   task automatic test_incdec();
      wr_pair(2'd2, 16'hFFFF);
      i_pair_sel = 2'd2; i_pair_op = 2'b01; i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'h0000) begin
         failures++; $display("FAIL inc_wrap_hl got=%h exp=0000", o_pair_data);
      end
      i_pair_sel = 2'd2; i_pair_op = 2'b10; i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'hFFFF) begin
         failures++; $display("FAIL dec_wrap_hl got=%h exp=ffff", o_pair_data);
      end
      // Reserved op is a no-op.
      i_pair_sel = 2'd2; i_pair_op = 2'b11; i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'hFFFF) begin
         failures++; $display("FAIL rsvd_op_hl got=%h exp=ffff", o_pair_data);
      end
      // AF holds 12/30 from the previous test; increment is ignored.
      i_pair_sel = 2'd3; i_pair_op = 2'b01; i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'h1230) begin
         failures++; $display("FAIL inc_af_ignored got=%h exp=1230", o_pair_data);
      end
   endtask

   task automatic test_conflict();
      i_pair_wr_en = 1'b1; i_pair_sel = 2'd2; i_pair_wr_data = 16'hABCD;
      i_wr_en = 1'b1; i_wr_addr = 3'd4; i_wr_data = 8'h11;
      i_rd_en_a = 1'b1; i_rd_addr_a = 3'd4;
      tick();
      checks++;
      if (o_rd_data_a !== 8'hAB) begin
         failures++; $display("FAIL pairwr_over_bytewr_h got=%h exp=ab", o_rd_data_a);
      end
      i_rd_en_b = 1'b1; i_rd_addr_b = 3'd5;
      tick();
      checks++;
      if (o_rd_data_b !== 8'hCD) begin
         failures++; $display("FAIL pairwr_l got=%h exp=cd", o_rd_data_b);
      end
      // Pair op beats byte write on the same byte.
      i_pair_sel = 2'd2; i_pair_op = 2'b10;
      i_wr_en = 1'b1; i_wr_addr = 3'd5; i_wr_data = 8'h99;
      i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'hABCC) begin
         failures++; $display("FAIL op_over_bytewr_hl got=%h exp=abcc", o_pair_data);
      end
   endtask

   task automatic test_back_to_back();
      wr_pair(2'd1, 16'h00FF);
      i_pair_sel = 2'd1; i_pair_op = 2'b01; i_pair_rd_en = 1'b1;
      i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 8'h77;
      tick();
      checks++;
      if (o_pair_data !== 16'h0100) begin
         failures++; $display("FAIL inc_de_carry got=%h exp=0100", o_pair_data);
      end
      i_rd_en_a = 1'b1; i_rd_addr_a = 3'd0;
      tick();
      checks++;
      if (o_rd_data_a !== 8'h77) begin
         failures++; $display("FAIL concurrent_b_write got=%h exp=77", o_rd_data_a);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] vals [8];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h70, 8'h88};
      for (int k = 0; k < 8; k++) begin
         wr_byte(3'(k), vals[k]);
      end
      i_pair_sel = 2'd0; i_pair_rd_en = 1'b1;
      tick();
      checks++;
      if (o_pair_data !== 16'h1122) begin
         failures++; $display("FAIL preload_bc got=%h exp=1122", o_pair_data);
      end
      i_reset = 1'b0;
      i_wr_en = 1'b1; i_wr_addr = 3'd7; i_wr_data = 8'hEE;
      i_pair_wr_en = 1'b1; i_pair_sel = 2'd2; i_pair_wr_data = 16'h5555;
      i_pair_rd_en = 1'b1;
      i_rd_en_a = 1'b1; i_rd_addr_a = 3'd7;
      i_rd_en_b = 1'b1; i_rd_addr_b = 3'd4;
      tick();
      checks++;
      if (o_rd_data_a !== 8'h00) begin
         failures++; $display("FAIL midreset_rd_a got=%h exp=00", o_rd_data_a);
      end
      checks++;
      if (o_rd_data_b !== 8'h00) begin
         failures++; $display("FAIL midreset_rd_b got=%h exp=00", o_rd_data_b);
      end
      checks++;
      if (o_pair_data !== 16'h0000) begin
         failures++; $display("FAIL midreset_pair got=%h exp=0000", o_pair_data);
      end
      for (int k = 0; k < 8; k++) begin
         i_rd_en_a = 1'b1; i_rd_addr_a = 3'(k);
         tick();
         checks++;
         if (o_rd_data_a !== 8'h00) begin
            failures++; $display("FAIL post_reset_reg%0d got=%h exp=00", k, o_rd_data_a);
         end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_pair_read();
      test_flag_mask();
      test_incdec();
      test_conflict();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
